// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that shares one external combinational ALU
// between two requesters. One operation is in flight at a time:
//   IDLE -> accept one request, latch operands
//   EXEC -> latch ALU result/flags into the response registers
//   RESP -> hold the response until rsp_valid && rsp_ready
//
// Parameters:
//   RR_INIT        last-granted index after reset (1 -> requester 0 wins first tie)
// Configuration macro:
//   ALU_ARBITER_FLAGS_EN  defined: rsp_flags registered from alu_flags
//                         undefined: rsp_flags tied to 0, alu_flags ignored
// Ports:
//   clk, rst                     clock, async active-high reset
//   req{0,1}_valid/ready         request handshake per requester
//   req{0,1}_a/_b/_op            operands and ALU control code
//   alu_a, alu_b, alu_ctrl       operands/control to the shared ALU (registered)
//   alu_result, alu_flags        combinational ALU outputs {Z,V,N,C}
//   rsp_valid/ready              response handshake
//   rsp_id, rsp_result, rsp_flags response owner, captured result and flags
module alu_arbiter #(
  parameter logic RR_INIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_nx;
  logic        last_grant;
  logic        accept;
  logic        grant_id;
  logic [31:0] opnd_a, opnd_b;
  logic [2:0]  opnd_ctrl;
  logic        opnd_id;

  // Grant: a lone requester wins; on a tie the one not granted last time wins.
  always_comb begin
    accept   = (state == IDLE) && (req0_valid || req1_valid);
    grant_id = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    req0_ready = accept && !grant_id;
    req1_ready = accept && grant_id;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = EXEC;
      EXEC: state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opnd_a     <= '0;
      opnd_b     <= '0;
      opnd_ctrl  <= '0;
      opnd_id    <= 1'b0;
      last_grant <= RR_INIT;
    end else if (accept) begin
      opnd_a     <= grant_id ? req1_a  : req0_a;
      opnd_b     <= grant_id ? req1_b  : req0_b;
      opnd_ctrl  <= grant_id ? req1_op : req0_op;
      opnd_id    <= grant_id;
      last_grant <= grant_id;
    end
  end

  assign alu_a    = opnd_a;
  assign alu_b    = opnd_b;
  assign alu_ctrl = opnd_ctrl;
  // The owner id only changes on accept, so it is stable throughout RESP.
  assign rsp_id   = opnd_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
    end else if (state == EXEC) begin
      rsp_valid  <= 1'b1;
      rsp_result <= alu_result;
    end else if (state == RESP && rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

`ifdef ALU_ARBITER_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 rsp_flags <= '0;
    else if (state == EXEC)  rsp_flags <= alu_flags;
  end
`else
  logic unused_flags;
  assign unused_flags = ^alu_flags;
  assign rsp_flags    = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed table, multi-cycle corner
// sequences and randomized traffic, all compared against a transaction-level
// reference model. The bench also plays the role of the shared ALU.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;
  logic [3:0]  alu_flags;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.RR_INIT(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags)
  );

  always #5 clk = ~clk;

  // Reference ALU: returns {Z,V,N,C, result}. C on subtract means borrow.
  function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    logic [32:0] w;
    logic [31:0] r;
    logic        v, c;
    v = 1'b0;
    c = 1'b0;
    case (op)
      3'd0: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[31:0];
        c = w[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1: begin
        r = a - b;
        c = (a < b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'd2: r = ~a;
      3'd3: r = a << b[4:0];
      3'd4: r = $unsigned($signed(a) >>> b[4:0]);
      3'd5: r = a & b;
      3'd6: r = a | b;
      default: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
    return {(r == 32'd0), v, r[31], c, r};
  endfunction

  always_comb {alu_flags, alu_result} = ref_alu(alu_a, alu_b, alu_ctrl);

  function automatic logic [3:0] flag_view(input logic [3:0] f);
`ifdef ALU_ARBITER_FLAGS_EN
    return f;
`else
    return 4'b0000 & f;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: at most one op outstanding; cycles since accept.
  bit          m_busy;
  int          m_age;
  bit          m_last;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_op;
  bit          m_id;

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_last = 1'b1;
    m_a = '0; m_b = '0; m_op = '0; m_id = 0;
  endtask

  task automatic clear_inputs();
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
  endtask

  // One clock: check outputs against the model, take the edge, advance model.
  task automatic cycle();
    bit g_any, g_id, resp_due;
    logic [35:0] e;
    #1;
    g_any    = !m_busy && (req0_valid || req1_valid);
    g_id     = (req0_valid && req1_valid) ? !m_last : req1_valid;
    resp_due = m_busy && (m_age >= 2);
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, g_any && !g_id});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, g_any && g_id});
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_ctrl", {29'd0, alu_ctrl}, {29'd0, m_op});
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, resp_due});
    if (resp_due) begin
      e = ref_alu(m_a, m_b, m_op);
      chk("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
      chk("rsp_result", rsp_result, e[31:0]);
      chk("rsp_flags", {28'd0, rsp_flags}, {28'd0, flag_view(e[35:32])});
    end
    @(posedge clk);
    if (g_any) begin
      m_a    = g_id ? req1_a  : req0_a;
      m_b    = g_id ? req1_b  : req0_b;
      m_op   = g_id ? req1_op : req0_op;
      m_id   = g_id;
      m_last = g_id;
      m_busy = 1;
      m_age  = 1;
    end else if (m_busy) begin
      if (resp_due && rsp_ready) m_busy = 0;
      else m_age++;
    end
    #1;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_flags", {28'd0, rsp_flags}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    bit          v0, v1;
    logic [31:0] a, b;
    logic [2:0]  op;
    bit          id;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  vec_t tbl[10];
  bit   ids[$];

  initial begin
    tbl[0] = '{1, 0, 32'd5,          32'd3,          3'b000, 0, 32'd8,          4'b0000};
    tbl[1] = '{0, 1, 32'd7,          32'd7,          3'b001, 1, 32'd0,          4'b1000};
    tbl[2] = '{1, 0, 32'h7FFF_FFFF,  32'd1,          3'b000, 0, 32'h8000_0000,  4'b0110};
    tbl[3] = '{0, 1, 32'd0,          32'd1,          3'b001, 1, 32'hFFFF_FFFF,  4'b0011};
    tbl[4] = '{1, 0, 32'h0F0F_0F0F,  32'd0,          3'b010, 0, 32'hF0F0_F0F0,  4'b0010};
    tbl[5] = '{0, 1, 32'd1,          32'd31,         3'b011, 1, 32'h8000_0000,  4'b0010};
    tbl[6] = '{1, 0, 32'h8000_0000,  32'd4,          3'b100, 0, 32'hF800_0000,  4'b0010};
    tbl[7] = '{0, 1, 32'h0000_FF00,  32'h0000_0F0F,  3'b101, 1, 32'h0000_0F00,  4'b0000};
    tbl[8] = '{1, 0, 32'd0,          32'd0,          3'b110, 0, 32'd0,          4'b1000};
    tbl[9] = '{0, 1, 32'hFFFF_FFFF,  32'd1,          3'b111, 1, 32'd1,          4'b0000};

    clear_inputs();
    rst = 1'b1;
    #2;
    do_reset();

    // Directed single transactions.
    for (int unsigned i = 0; i < 10; i++) begin
      req0_valid = tbl[i].v0; req0_a = tbl[i].a; req0_b = tbl[i].b; req0_op = tbl[i].op;
      req1_valid = tbl[i].v1; req1_a = tbl[i].a; req1_b = tbl[i].b; req1_op = tbl[i].op;
      cycle();
      req0_valid = 0; req1_valid = 0;
      cycle();
      chk("tbl_valid", {31'd0, rsp_valid}, 32'd1);
      chk("tbl_id", {31'd0, rsp_id}, {31'd0, tbl[i].id});
      chk("tbl_result", rsp_result, tbl[i].res);
      chk("tbl_flags", {28'd0, rsp_flags}, {28'd0, flag_view(tbl[i].flg)});
      rsp_ready = 1;
      cycle();
      rsp_ready = 0;
    end

    // Both requesters always valid: grants must alternate starting at 0.
    do_reset();
    req0_valid = 1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 3'b000;
    req1_valid = 1; req1_a = 32'd7; req1_b = 32'd7; req1_op = 3'b001;
    rsp_ready = 1;
    ids.delete();
    for (int unsigned i = 0; i < 12; i++) begin
      cycle();
      if (rsp_valid) begin
        ids.push_back(rsp_id);
        if (rsp_id) begin
          chk("rr_sub_result", rsp_result, 32'd0);
          chk("rr_sub_flags", {28'd0, rsp_flags}, {28'd0, flag_view(4'b1000)});
        end
      end
    end
    chk("rr_count", ids.size(), 32'd4);
    for (int unsigned k = 0; k < 4 && k < ids.size(); k++)
      chk("rr_order", {31'd0, ids[k]}, {31'd0, k[0]});
    clear_inputs();
    cycle();
    cycle();

    // Response held while consumer stalls; other requester waits, operands churn.
    do_reset();
    req0_valid = 1; req0_a = 32'h7FFF_FFFF; req0_b = 32'd1; req0_op = 3'b000;
    cycle();
    req0_valid = 0;
    req1_valid = 1;
    cycle();
    for (int unsigned i = 0; i < 5; i++) begin
      req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom_range(0, 7));
      chk("hold_result", rsp_result, 32'h8000_0000);
      chk("hold_flags", {28'd0, rsp_flags}, {28'd0, flag_view(4'b0110)});
      cycle();
    end
    rsp_ready = 1;
    cycle();
    rsp_ready = 0;
    cycle();
    req1_valid = 0;
    for (int unsigned i = 0; i < 3; i++) begin
      rsp_ready = (i == 2);
      cycle();
    end
    clear_inputs();

    // Reset during EXEC drops the operation; RR pointer returns to RR_INIT.
    do_reset();
    req0_valid = 1; req0_a = 32'd9; req0_b = 32'd1; req0_op = 3'b000;
    cycle();
    req0_valid = 0;
    rsp_ready = 1;
    cycle();
    cycle();
    rsp_ready = 0;
    req1_valid = 1; req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 3'b110;
    cycle();
    req1_valid = 0;
    do_reset();
    for (int unsigned i = 0; i < 3; i++) cycle();
    req0_valid = 1; req1_valid = 1;
    req0_a = 32'd2; req0_b = 32'd2; req0_op = 3'b000;
    #1;
    chk("post_rst_grant0", {31'd0, req0_ready}, 32'd1);
    chk("post_rst_grant1", {31'd0, req1_ready}, 32'd0);
    cycle();
    clear_inputs();
    rsp_ready = 1;
    cycle();
    cycle();
    cycle();

    // Randomized traffic.
    for (int unsigned i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_a = $urandom; req0_b = $urandom; req0_op = 3'($urandom_range(0, 7));
      req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom_range(0, 7));
      rsp_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
